// File: rtl/tron_arena.sv
// Multi-player Tron arena: per-cell trail owner memory, stepped player movement with
// wall/trail/head-on collision detection, and a registered pixel colour path.
module tron_arena #(
    parameter int NUM_P       = 2,
    parameter int GRID_W      = 200,
    parameter int GRID_H      = 150,
    parameter int CELL_LOG2   = 2,
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int STEP_FRAMES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         row,
    input  logic [9:0]         col,
    input  logic [2*NUM_P-1:0] dir_in,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic [NUM_P-1:0]   alive,
    output logic               game_over,
    output logic [2:0]         winner,
    output logic               busy
);

    localparam int CELLS     = GRID_W * GRID_H;
    localparam int AW        = $clog2(CELLS);
    localparam int XW        = $clog2(GRID_W) + 1;
    localparam int YW        = $clog2(GRID_H) + 1;
    localparam int IW        = $clog2(NUM_P);
    localparam int X_SPACING = (GRID_W - 2) / NUM_P;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_PLAY, S_PROBE, S_CHECK, S_HEADON, S_COMMIT, S_OVER
    } state_t;

    function automatic logic [XW-1:0] start_x(input int i);
        return XW'(1 + i * X_SPACING);
    endfunction

    function automatic logic [YW-1:0] start_y(input int i);
        return (i % 2 == 0) ? YW'(GRID_H - 2) : YW'(1);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(32'(y) * 32'(GRID_W) + 32'(x));
    endfunction

    function automatic logic [2:0] start_owner(input logic [AW-1:0] a);
        logic [2:0] o;
        o = 3'd0;
        for (int i = 0; i < NUM_P; i++) begin
            o = (a == cell_addr(start_x(i), start_y(i))) ? 3'(i + 1) : o;
        end
        return o;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [AW-1:0]    clr_addr_r;
    logic             clr_play_r;
    logic [3:0]       frame_cnt_r;
    logic [IW-1:0]    idx_r;
    logic [XW-1:0]    head_x_r [NUM_P];
    logic [YW-1:0]    head_y_r [NUM_P];
    logic [1:0]       heading_r [NUM_P];
    logic [XW-1:0]    next_x_r [NUM_P];
    logic [YW-1:0]    next_y_r [NUM_P];
    logic [NUM_P-1:0] alive_r, crash_r;
    logic             game_over_r;
    logic [2:0]       winner_r;
    logic [7:0]       red_r, green_r, blue_r;
    logic [2:0]       owner_mem [CELLS];
    logic [2:0]       probe_rd_r;

    logic             frame_tick_s, step_due_s, last_clr_s, last_idx_s;
    logic [XW-1:0]    probe_x_s;
    logic [YW-1:0]    probe_y_s;
    logic             probe_wall_s;
    logic [NUM_P-1:0] alive_after_s;
    logic [2:0]       live_cnt_s, winner_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_wa_s;
    logic [2:0]       mem_wd_s;
    logic [9:0]       prow_s, pcol_s;
    logic             pix_in_grid_s, head_hit_s, show_heads_s;
    logic [AW-1:0]    pix_addr_s;
    logic [2:0]       pix_owner_s;
    logic [23:0]      pix_rgb_s;

    assign frame_tick_s = (row == 10'(SCREEN_H - 1)) && (col == 10'(SCREEN_W - 1));
    assign step_due_s   = frame_tick_s && (frame_cnt_r == 4'(STEP_FRAMES - 1));
    assign last_clr_s   = (clr_addr_r == AW'(CELLS - 1));
    assign last_idx_s   = (idx_r == IW'(NUM_P - 1));

    // Candidate next cell of the player being probed; edge tests avoid relying on wrap.
    always_comb begin
        probe_x_s    = head_x_r[idx_r];
        probe_y_s    = head_y_r[idx_r];
        probe_wall_s = 1'b0;
        case (heading_r[idx_r])
            2'd0: begin
                probe_wall_s = (head_y_r[idx_r] == YW'(0));
                probe_y_s    = head_y_r[idx_r] - YW'(1);
            end
            2'd1: begin
                probe_wall_s = (head_x_r[idx_r] == XW'(GRID_W - 1));
                probe_x_s    = head_x_r[idx_r] + XW'(1);
            end
            2'd2: begin
                probe_wall_s = (head_y_r[idx_r] == YW'(GRID_H - 1));
                probe_y_s    = head_y_r[idx_r] + YW'(1);
            end
            2'd3: begin
                probe_wall_s = (head_x_r[idx_r] == XW'(0));
                probe_x_s    = head_x_r[idx_r] - XW'(1);
            end
            default: probe_wall_s = 1'b1;
        endcase
    end

    // Survivor set as it will stand after the current commit slot, for the round verdict.
    always_comb begin
        alive_after_s = alive_r;
        alive_after_s[idx_r] = alive_r[idx_r] & ~crash_r[idx_r];
        live_cnt_s = 3'd0;
        winner_s   = 3'd0;
        for (int i = 0; i < NUM_P; i++) begin
            live_cnt_s = live_cnt_s + {2'b00, alive_after_s[i]};
            winner_s   = alive_after_s[i] ? 3'(i + 1) : winner_s;
        end
    end

    // Next-state decode and owner-memory write port control.
    always_comb begin
        state_nxt_s = state_r;
        mem_we_s    = 1'b0;
        mem_wa_s    = {AW{1'b0}};
        mem_wd_s    = 3'd0;
        case (state_r)
            S_CLEAR: begin
                mem_we_s = 1'b1;
                mem_wa_s = clr_addr_r;
                mem_wd_s = clr_play_r ? start_owner(clr_addr_r) : 3'd0;
                if (last_clr_s) begin
                    state_nxt_s = clr_play_r ? S_PLAY : S_IDLE;
                end else begin
                    state_nxt_s = S_CLEAR;
                end
            end
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_nxt_s = S_CLEAR;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_PLAY: begin
                if (step_due_s) begin
                    state_nxt_s = S_PROBE;
                end else begin
                    state_nxt_s = S_PLAY;
                end
            end
            S_PROBE: begin
                if (!alive_r[idx_r] || probe_wall_s) begin
                    state_nxt_s = last_idx_s ? S_HEADON : S_PROBE;
                end else begin
                    state_nxt_s = S_CHECK;
                end
            end
            S_CHECK:  state_nxt_s = last_idx_s ? S_HEADON : S_PROBE;
            S_HEADON: state_nxt_s = S_COMMIT;
            S_COMMIT: begin
                if (alive_r[idx_r] && !crash_r[idx_r]) begin
                    mem_we_s = 1'b1;
                    mem_wa_s = cell_addr(next_x_r[idx_r], next_y_r[idx_r]);
                    mem_wd_s = 3'(idx_r) + 3'd1;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (last_idx_s) begin
                    state_nxt_s = (live_cnt_s <= 3'd1) ? S_OVER : S_PLAY;
                end else begin
                    state_nxt_s = S_COMMIT;
                end
            end
            default: state_nxt_s = S_CLEAR;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Owner memory: one write port, a probe read port registered for the step engine.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            owner_mem[mem_wa_s] <= mem_wd_s;
        end
        probe_rd_r <= owner_mem[cell_addr(probe_x_s, probe_y_s)];
    end

    // Game datapath: clear sweep, frame pacing, probe/head-on/commit bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_addr_r  <= {AW{1'b0}};
            clr_play_r  <= 1'b0;
            frame_cnt_r <= 4'd0;
            idx_r       <= {IW{1'b0}};
            alive_r     <= {NUM_P{1'b0}};
            crash_r     <= {NUM_P{1'b0}};
            game_over_r <= 1'b0;
            winner_r    <= 3'd0;
            for (int i = 0; i < NUM_P; i++) begin
                head_x_r[i]  <= {XW{1'b0}};
                head_y_r[i]  <= {YW{1'b0}};
                heading_r[i] <= 2'd0;
                next_x_r[i]  <= {XW{1'b0}};
                next_y_r[i]  <= {YW{1'b0}};
            end
        end else begin
            case (state_r)
                S_CLEAR: begin
                    if (last_clr_s) begin
                        clr_addr_r <= {AW{1'b0}};
                        clr_play_r <= 1'b0;
                        if (clr_play_r) begin
                            alive_r     <= {NUM_P{1'b1}};
                            frame_cnt_r <= 4'd0;
                            for (int i = 0; i < NUM_P; i++) begin
                                head_x_r[i]  <= start_x(i);
                                head_y_r[i]  <= start_y(i);
                                heading_r[i] <= (i % 2 == 0) ? 2'd0 : 2'd2;
                            end
                        end
                    end else begin
                        clr_addr_r <= clr_addr_r + AW'(1);
                    end
                end
                S_IDLE, S_OVER: begin
                    if (start) begin
                        clr_addr_r  <= {AW{1'b0}};
                        clr_play_r  <= 1'b1;
                        alive_r     <= {NUM_P{1'b0}};
                        game_over_r <= 1'b0;
                        winner_r    <= 3'd0;
                    end
                end
                S_PLAY: begin
                    if (step_due_s) begin
                        frame_cnt_r <= 4'd0;
                        idx_r       <= {IW{1'b0}};
                        crash_r     <= {NUM_P{1'b0}};
                        for (int i = 0; i < NUM_P; i++) begin
                            // A reversal request would drive straight into the own trail.
                            if (alive_r[i] && ((dir_in[2*i +: 2] ^ heading_r[i]) != 2'b10)) begin
                                heading_r[i] <= dir_in[2*i +: 2];
                            end
                        end
                    end else if (frame_tick_s) begin
                        frame_cnt_r <= frame_cnt_r + 4'd1;
                    end
                end
                S_PROBE: begin
                    next_x_r[idx_r] <= probe_x_s;
                    next_y_r[idx_r] <= probe_y_s;
                    if (alive_r[idx_r] && probe_wall_s) begin
                        crash_r[idx_r] <= 1'b1;
                    end
                    if (!alive_r[idx_r] || probe_wall_s) begin
                        idx_r <= last_idx_s ? {IW{1'b0}} : idx_r + IW'(1);
                    end
                end
                S_CHECK: begin
                    if (probe_rd_r != 3'd0) begin
                        crash_r[idx_r] <= 1'b1;
                    end
                    idx_r <= last_idx_s ? {IW{1'b0}} : idx_r + IW'(1);
                end
                S_HEADON: begin
                    idx_r <= {IW{1'b0}};
                    for (int i = 0; i < NUM_P; i++) begin
                        for (int j = i + 1; j < NUM_P; j++) begin
                            if (alive_r[i] && alive_r[j] &&
                                next_x_r[i] == next_x_r[j] && next_y_r[i] == next_y_r[j]) begin
                                crash_r[i] <= 1'b1;
                                crash_r[j] <= 1'b1;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    if (alive_r[idx_r]) begin
                        if (crash_r[idx_r]) begin
                            alive_r[idx_r] <= 1'b0;
                        end else begin
                            head_x_r[idx_r] <= next_x_r[idx_r];
                            head_y_r[idx_r] <= next_y_r[idx_r];
                        end
                    end
                    idx_r <= last_idx_s ? {IW{1'b0}} : idx_r + IW'(1);
                    if (last_idx_s && live_cnt_s <= 3'd1) begin
                        game_over_r <= 1'b1;
                        winner_r    <= winner_s;
                    end
                end
                default: clr_addr_r <= {AW{1'b0}};
            endcase
        end
    end

    assign prow_s        = row >> CELL_LOG2;
    assign pcol_s        = col >> CELL_LOG2;
    assign pix_in_grid_s = (prow_s < 10'(GRID_H)) && (pcol_s < 10'(GRID_W));
    assign pix_addr_s    = AW'(32'(prow_s) * 32'(GRID_W) + 32'(pcol_s));
    assign pix_owner_s   = owner_mem[pix_addr_s];
    assign show_heads_s  = (state_r != S_CLEAR) && (state_r != S_IDLE);

    // Pixel colour lookup; heads override trails, whether the player lives or not.
    always_comb begin
        head_hit_s = 1'b0;
        for (int i = 0; i < NUM_P; i++) begin
            head_hit_s = head_hit_s |
                         ((10'(head_x_r[i]) == pcol_s) && (10'(head_y_r[i]) == prow_s));
        end
        pix_rgb_s = 24'h000000;
        if (!pix_in_grid_s) begin
            pix_rgb_s = 24'h000000;
        end else if (show_heads_s && head_hit_s) begin
            pix_rgb_s = 24'hFFFFFF;
        end else begin
            case (pix_owner_s)
                3'd1:    pix_rgb_s = 24'hFF0000;
                3'd2:    pix_rgb_s = 24'h00FFFF;
                3'd3:    pix_rgb_s = 24'hFFFF00;
                3'd4:    pix_rgb_s = 24'h00FF00;
                default: pix_rgb_s = 24'h000000;
            endcase
        end
    end

    // Registered colour output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            red_r   <= 8'd0;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
        end else begin
            {red_r, green_r, blue_r} <= pix_rgb_s;
        end
    end

    assign red       = red_r;
    assign green     = green_r;
    assign blue      = blue_r;
    assign alive     = alive_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;
    assign busy      = (state_r == S_CLEAR) || (state_r == S_PROBE) || (state_r == S_CHECK) ||
                       (state_r == S_HEADON) || (state_r == S_COMMIT);

endmodule

// File: tb/tb_tron_arena.sv
// Directed bench for tron_arena on an 8x8 grid (32x32 px screen, 4 frames per step).
module tb_tron_arena;
    localparam int NP = 2;
    localparam int GW = 8;
    localparam int GH = 8;
    localparam int SW = 32;
    localparam int SH = 32;
    localparam int SF = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    row = 10'd0;
    logic [9:0]    col = 10'd0;
    logic [2*NP-1:0] dir_in = 4'd0;
    logic [7:0]    red, green, blue;
    logic [NP-1:0] alive;
    logic          game_over;
    logic [2:0]    winner;
    logic          busy;

    int total = 0;
    int bad   = 0;

    tron_arena #(
        .NUM_P(NP), .GRID_W(GW), .GRID_H(GH), .CELL_LOG2(2),
        .SCREEN_W(SW), .SCREEN_H(SH), .STEP_FRAMES(SF)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .row(row), .col(col),
        .dir_in(dir_in), .red(red), .green(green), .blue(blue),
        .alive(alive), .game_over(game_over), .winner(winner), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_pix(input string tag, input int cx, input int cy, input logic [23:0] exp);
        row = 10'(cy * 4 + 1);
        col = 10'(cx * 4 + 2);
        cyc(1);
        check(tag, {8'h00, red, green, blue}, {8'h00, exp});
        row = 10'd0;
        col = 10'd0;
    endtask

    task automatic frame_tick();
        row = 10'(SH - 1);
        col = 10'(SW - 1);
        cyc(1);
        row = 10'd0;
        col = 10'd0;
        cyc(1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_step(input logic [1:0] d0, input logic [1:0] d1);
        dir_in = {d1, d0};
        repeat (SF) frame_tick();
        wait_idle("step_done");
    endtask

    task automatic start_round();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        wait_idle("clear_done");
        check("round_alive", {30'd0, alive}, 32'd3);
    endtask

    initial begin
        // Reset values and reset-initiated clear length.
        cyc(3);
        check("rst_alive", {30'd0, alive}, 32'd0);
        check("rst_rgb", {8'h00, red, green, blue}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        cyc(GW * GH - 1);
        check("clear_last", {31'd0, busy}, 32'd1);
        cyc(1);
        check("clear_end", {31'd0, busy}, 32'd0);
        check("idle_gover", {31'd0, game_over}, 32'd0);
        check("idle_winner", {29'd0, winner}, 32'd0);
        check_pix("idle_p0start", 1, 6, 24'h000000);
        check_pix("idle_p1start", 4, 1, 24'h000000);
        row = 10'd300;
        col = 10'd400;
        cyc(1);
        check("idle_offgrid", {8'h00, red, green, blue}, 32'd0);
        row = 10'd0;
        col = 10'd0;

        // Round 1: straight run, then P0 exits the left wall.
        start_round();
        do_step(2'd0, 2'd2);
        do_step(2'd0, 2'd2);
        do_step(2'd0, 2'd2);
        check("r1_alive", {30'd0, alive}, 32'd3);
        check("r1_gover", {31'd0, game_over}, 32'd0);
        check_pix("r1_p0head", 1, 3, 24'hFFFFFF);
        check_pix("r1_trail6", 1, 6, 24'hFF0000);
        check_pix("r1_trail5", 1, 5, 24'hFF0000);
        check_pix("r1_trail4", 1, 4, 24'hFF0000);
        check_pix("r1_p1start", 4, 1, 24'h00FFFF);
        check_pix("r1_p1head", 4, 4, 24'hFFFFFF);
        do_step(2'd3, 2'd2);
        check("r1_edge_alive", {30'd0, alive}, 32'd3);
        check_pix("r1_edge_head", 0, 3, 24'hFFFFFF);
        do_step(2'd3, 2'd2);
        check("r1_wall_alive", {30'd0, alive}, 32'd2);
        check("r1_wall_gover", {31'd0, game_over}, 32'd1);
        check("r1_wall_winner", {29'd0, winner}, 32'd2);
        check_pix("r1_oldhead", 1, 3, 24'hFF0000);
        check_pix("r1_p1final", 4, 6, 24'hFFFFFF);
        repeat (SF) frame_tick();
        check("r1_over_busy", {31'd0, busy}, 32'd0);
        check("r1_over_alive", {30'd0, alive}, 32'd2);
        check_pix("r1_frozen", 0, 3, 24'hFFFFFF);

        // Round 2: both players converge on cell (3,4) in the same step.
        start_round();
        do_step(2'd0, 2'd2);
        do_step(2'd0, 2'd2);
        do_step(2'd1, 2'd2);
        check("r2_pre_alive", {30'd0, alive}, 32'd3);
        check("r2_pre_gover", {31'd0, game_over}, 32'd0);
        do_step(2'd1, 2'd3);
        check("r2_ho_alive", {30'd0, alive}, 32'd0);
        check("r2_ho_gover", {31'd0, game_over}, 32'd1);
        check("r2_ho_winner", {29'd0, winner}, 32'd0);
        check_pix("r2_meet_empty", 3, 4, 24'h000000);
        check_pix("r2_p0frozen", 2, 4, 24'hFFFFFF);
        check_pix("r2_p1frozen", 4, 4, 24'hFFFFFF);

        // Round 3: start coincides with a frame tick; P1 requests reversal; P0 hits P1 trail.
        row = 10'(SH - 1);
        col = 10'(SW - 1);
        start_round();
        row = 10'd0;
        col = 10'd0;
        do_step(2'd1, 2'd0);
        check_pix("r3_p1_noreverse", 4, 2, 24'hFFFFFF);
        check_pix("r3_p0head", 2, 6, 24'hFFFFFF);
        do_step(2'd1, 2'd0);
        do_step(2'd0, 2'd0);
        do_step(2'd0, 2'd0);
        do_step(2'd0, 2'd0);
        check("r3_pre_alive", {30'd0, alive}, 32'd3);
        do_step(2'd1, 2'd0);
        check("r3_trail_alive", {30'd0, alive}, 32'd2);
        check("r3_trail_gover", {31'd0, game_over}, 32'd1);
        check("r3_trail_winner", {29'd0, winner}, 32'd2);
        check_pix("r3_p1head", 4, 7, 24'hFFFFFF);
        check_pix("r3_p0frozen", 3, 3, 24'hFFFFFF);
        check_pix("r3_hitcell", 4, 3, 24'h00FFFF);

        // Round 4: reset in the middle of a step.
        start_round();
        dir_in = 4'b1000;
        repeat (SF - 1) frame_tick();
        row = 10'(SH - 1);
        col = 10'(SW - 1);
        cyc(1);
        row = 10'd25;
        col = 10'd5;
        cyc(1);
        check("r4_midstep_busy", {31'd0, busy}, 32'd1);
        check("r4_midstep_rgb", {8'h00, red, green, blue}, 32'h00FFFFFF);
        #2;
        reset = 1'b0;
        #1;
        check("r4_rst_alive", {30'd0, alive}, 32'd0);
        check("r4_rst_rgb", {8'h00, red, green, blue}, 32'd0);
        check("r4_rst_busy", {31'd0, busy}, 32'd1);
        check("r4_rst_winner", {29'd0, winner}, 32'd0);
        row = 10'd0;
        col = 10'd0;
        cyc(2);
        reset = 1'b1;
        wait_idle("r4_clear_done");
        check("r4_idle_alive", {30'd0, alive}, 32'd0);
        check("r4_idle_gover", {31'd0, game_over}, 32'd0);
        check_pix("r4_p0start_gone", 1, 6, 24'h000000);
        check_pix("r4_p1start_gone", 4, 1, 24'h000000);
        check_pix("r4_p0next_gone", 1, 5, 24'h000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
